adc_spi_slave: RTL and testbench
================================

ADC_SPI_SLAVE -- requirements
Module: adc_spi_slave

Interface
REQ-001 The module SHALL have one clock, CLK; all state SHALL update on the rising edge of CLK.
REQ-002 Reset SHALL be synchronous and active-low on RESET_N.
REQ-003 Port CLK  input  1  system clock; must run at least 4x the ADC_SCLK frequency.
REQ-004 Port RESET_N  input  1  synchronous active-low reset.
REQ-005 Port ADC_SLOAD  input  1  frame select, active low; asynchronous to CLK.
REQ-006 Port ADC_SCLK  input  1  serial clock; data is valid on its rising edge; asynchronous to CLK.
REQ-007 Port ADC_SDATA  input  1  serial data, MSB first; asynchronous to CLK.
REQ-008 Port CONFIG  output  9  shadow of register address 0.
REQ-009 Port GAIN  output  6  bits [5:0] of register address 2.
REQ-010 Port OFFSET  output  9  shadow of register address 5.
REQ-011 Port WR_STROBE  output  1  one-cycle pulse on every committed write.
REQ-012 Port WR_ADDR  output  3  address of the last committed write.
REQ-013 Port WR_DATA  output  9  data of the last committed write.
REQ-014 Port RD_REQ  output  1  one-cycle pulse on every valid frame with R/W=1.
REQ-015 Port FRAME_ERR  output  1  one-cycle pulse on every malformed frame.
REQ-016 Port FRAME_CNT  output  8  count of valid frames; wraps 255 -> 0.

Function
REQ-017 ADC_SLOAD, ADC_SCLK and ADC_SDATA SHALL each pass through a 2-flop synchronizer; all logic SHALL use only the synchronized copies.
REQ-018 An SCLK rising edge SHALL be detected as synchronized SCLK = 1 in the current cycle and 0 in the previous cycle.
REQ-019 The frame word SHALL be 16 bits: [15] R/W (1 = read), [14:12] address, [11:9] don't care, [8:0] data.
REQ-020 The FSM SHALL have the states IDLE, SHIFT and OVERRUN.
REQ-021 IDLE SHALL move to SHIFT on a synchronized SLOAD falling edge (1 -> 0), clearing the bit counter and the shift register.
REQ-022 If SLOAD is low on reset release, the block SHALL stay in IDLE until SLOAD has been seen high and then falls.
REQ-023 In SHIFT, each detected SCLK rising edge while synchronized SLOAD = 0 SHALL shift in synchronized SDATA at the LSB and increment the bit counter (5 bits).
REQ-024 An SCLK edge sampled in the same cycle as synchronized SLOAD = 1 SHALL be ignored.
REQ-025 A 17th SCLK edge in SHIFT SHALL move the FSM to OVERRUN.
REQ-026 OVERRUN SHALL ignore SCLK, pulse FRAME_ERR once on SLOAD rising, and return to IDLE.
REQ-027 On SLOAD rising in SHIFT with counter = 16 and R/W = 0, the block SHALL, in the next cycle, write data[8:0] to register[address], load WR_ADDR/WR_DATA, pulse WR_STROBE, increment FRAME_CNT, and return to IDLE.
REQ-028 On SLOAD rising in SHIFT with counter = 16 and R/W = 1, the block SHALL pulse RD_REQ and increment FRAME_CNT, leave all registers, WR_ADDR and WR_DATA unchanged, and return to IDLE.
REQ-029 On SLOAD rising in SHIFT with counter < 16 (including 0), the block SHALL pulse FRAME_ERR, leave the registers unchanged, and return to IDLE.
REQ-030 The register file SHALL be 8 x 9 bits; CONFIG, GAIN and OFFSET SHALL reflect registers 0, 2[5:0] and 5 combinationally from the register flops.
REQ-031 Latency from the ADC_SLOAD pin rising to WR_STROBE SHALL be at most 4 CLK cycles.
REQ-032 WR_STROBE, RD_REQ and FRAME_ERR SHALL never be high in the same cycle.
REQ-033 Back-to-back frames separated by one SCLK period of SLOAD high SHALL all be received with no loss.

Reset
REQ-034 RESET_N = 0 at a CLK edge SHALL set the FSM to IDLE and clear the counter and shift register.
REQ-035 Reset SHALL clear all 8 registers to 0 and drive CONFIG = 0, GAIN = 0, OFFSET = 0, WR_ADDR = 0, WR_DATA = 0, FRAME_CNT = 0.
REQ-036 Reset SHALL drive WR_STROBE, RD_REQ and FRAME_ERR low.
REQ-037 The synchronizer flops SHALL reset to SLOAD = 1, SCLK = 0, SDATA = 0.
REQ-038 Reset in mid-frame SHALL discard the frame with no strobe.
REQ-039 After a mid-frame reset the block SHALL wait for a new SLOAD falling edge before accepting data.

Verification
REQ-040 Write word 0x0050 (CLK = 8x SCLK) -> CONFIG = 0x050, WR_STROBE one pulse, WR_ADDR = 0, FRAME_CNT = 1.
REQ-041 Write words 0x2025 then 0x51FF back-to-back -> GAIN = 6'h25, OFFSET = 0x1FF, two WR_STROBE pulses, FRAME_CNT = 2.
REQ-042 Frame with 12 SCLK edges, then a frame with 18 edges -> two FRAME_ERR pulses, registers unchanged, FRAME_CNT unchanged.
REQ-043 Read word 0xD000 -> RD_REQ one pulse, OFFSET unchanged, no WR_STROBE.
REQ-044 RESET_N low after bit 8 of a frame, then released -> all outputs 0, the remainder of the frame is ignored, and the next full frame is accepted.
REQ-045 256 valid frames -> FRAME_CNT wraps to 0.

Source files
------------

// File: rtl/adc_spi_slave.sv
// Serial register-write slave for an ADC control port.
// 16-bit frames on SLOAD/SCLK/SDATA update an 8 x 9-bit register file.
module adc_spi_slave (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       ADC_SLOAD,
    input  logic       ADC_SCLK,
    input  logic       ADC_SDATA,
    output logic [8:0] CONFIG,
    output logic [5:0] GAIN,
    output logic [8:0] OFFSET,
    output logic       WR_STROBE,
    output logic [2:0] WR_ADDR,
    output logic [8:0] WR_DATA,
    output logic       RD_REQ,
    output logic       FRAME_ERR,
    output logic [7:0] FRAME_CNT
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        OVERRUN = 2'd2
    } state_t;

    state_t      state;
    logic        sload_meta;
    logic        sload_sync;
    logic        sload_prev;
    logic        sclk_meta;
    logic        sclk_sync;
    logic        sclk_prev;
    logic        sdata_meta;
    logic        sdata_sync;
    logic [1:0]  warm;
    logic        armed;
    logic [4:0]  bit_cnt;
    logic [15:0] shreg;
    logic [8:0]  regs [8];

    logic sclk_rise;
    logic sload_rise;
    logic sload_fall;
    logic full_word;

    assign sclk_rise  = sclk_sync & ~sclk_prev;
    assign sload_rise = sload_sync & ~sload_prev;
    // A fall only counts once SLOAD has really been seen high.
    assign sload_fall = armed & sload_prev & ~sload_sync;
    assign full_word  = (bit_cnt == 5'd16);

    assign CONFIG = regs[0];
    assign GAIN   = regs[2][5:0];
    assign OFFSET = regs[5];

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state      <= IDLE;
            sload_meta <= 1'b1;
            sload_sync <= 1'b1;
            sload_prev <= 1'b1;
            sclk_meta  <= 1'b0;
            sclk_sync  <= 1'b0;
            sclk_prev  <= 1'b0;
            sdata_meta <= 1'b0;
            sdata_sync <= 1'b0;
            warm       <= 2'b00;
            armed      <= 1'b0;
            bit_cnt    <= 5'd0;
            shreg      <= 16'd0;
            WR_STROBE  <= 1'b0;
            RD_REQ     <= 1'b0;
            FRAME_ERR  <= 1'b0;
            WR_ADDR    <= 3'd0;
            WR_DATA    <= 9'd0;
            FRAME_CNT  <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 9'd0;
            end
        end else begin
            sload_meta <= ADC_SLOAD;
            sload_sync <= sload_meta;
            sload_prev <= sload_sync;
            sclk_meta  <= ADC_SCLK;
            sclk_sync  <= sclk_meta;
            sclk_prev  <= sclk_sync;
            sdata_meta <= ADC_SDATA;
            sdata_sync <= sdata_meta;
            // warm[1] marks the synchronizer as flushed of reset values.
            warm       <= {warm[0], 1'b1};
            armed      <= armed | (warm[1] & sload_sync);
            WR_STROBE  <= 1'b0;
            RD_REQ     <= 1'b0;
            FRAME_ERR  <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (sload_fall) begin
                        state   <= SHIFT;
                        bit_cnt <= 5'd0;
                        shreg   <= 16'd0;
                    end
                end
                SHIFT: begin
                    if (sload_rise) begin
                        state <= IDLE;
                        if (!full_word) begin
                            FRAME_ERR <= 1'b1;
                        end else if (shreg[15]) begin
                            RD_REQ    <= 1'b1;
                            FRAME_CNT <= FRAME_CNT + 8'd1;
                        end else begin
                            regs[shreg[14:12]] <= shreg[8:0];
                            WR_ADDR   <= shreg[14:12];
                            WR_DATA   <= shreg[8:0];
                            WR_STROBE <= 1'b1;
                            FRAME_CNT <= FRAME_CNT + 8'd1;
                        end
                    end else if (sclk_rise && !sload_sync) begin
                        if (full_word) begin
                            state <= OVERRUN;
                        end else begin
                            shreg   <= {shreg[14:0], sdata_sync};
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                OVERRUN: begin
                    if (sload_rise) begin
                        FRAME_ERR <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_slave.sv
// Randomized bench for adc_spi_slave against a frame-level reference model.
module tb_adc_spi_slave;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       ADC_SLOAD = 1'b0;
    logic       ADC_SCLK = 1'b0;
    logic       ADC_SDATA = 1'b0;
    logic [8:0] CONFIG;
    logic [5:0] GAIN;
    logic [8:0] OFFSET;
    logic       WR_STROBE;
    logic [2:0] WR_ADDR;
    logic [8:0] WR_DATA;
    logic       RD_REQ;
    logic       FRAME_ERR;
    logic [7:0] FRAME_CNT;

    adc_spi_slave dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .ADC_SLOAD(ADC_SLOAD),
        .ADC_SCLK(ADC_SCLK),
        .ADC_SDATA(ADC_SDATA),
        .CONFIG(CONFIG),
        .GAIN(GAIN),
        .OFFSET(OFFSET),
        .WR_STROBE(WR_STROBE),
        .WR_ADDR(WR_ADDR),
        .WR_DATA(WR_DATA),
        .RD_REQ(RD_REQ),
        .FRAME_ERR(FRAME_ERR),
        .FRAME_CNT(FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_pass = 0;

    int n_wr = 0;
    int n_rd = 0;
    int n_err = 0;
    int n_ovl = 0;

    logic [8:0] exp_regs [8];
    logic [2:0] exp_waddr;
    logic [8:0] exp_wdata;
    int         exp_cnt;
    int         exp_wr = 0;
    int         exp_rd = 0;
    int         exp_err = 0;

    always @(negedge CLK) begin
        n_wr  += int'(WR_STROBE);
        n_rd  += int'(RD_REQ);
        n_err += int'(FRAME_ERR);
        if (int'(WR_STROBE) + int'(RD_REQ) + int'(FRAME_ERR) > 1)
            n_ovl++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                      tag, got, got, exp, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) exp_regs[i] = 9'd0;
        exp_waddr = 3'd0;
        exp_wdata = 9'd0;
        exp_cnt   = 0;
    endtask

    // Frame-level rule: exactly 16 edges is valid, anything else is an error.
    task automatic model_frame(input logic [15:0] w, input int n);
        if (n != 16) begin
            exp_err++;
        end else if (w[15]) begin
            exp_rd++;
            exp_cnt = (exp_cnt + 1) % 256;
        end else begin
            exp_regs[w[14:12]] = w[8:0];
            exp_waddr = w[14:12];
            exp_wdata = w[8:0];
            exp_wr++;
            exp_cnt = (exp_cnt + 1) % 256;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".config"}, int'(CONFIG), int'(exp_regs[0]));
        check({tag, ".gain"}, int'(GAIN), int'(exp_regs[2][5:0]));
        check({tag, ".offset"}, int'(OFFSET), int'(exp_regs[5]));
        check({tag, ".wr_addr"}, int'(WR_ADDR), int'(exp_waddr));
        check({tag, ".wr_data"}, int'(WR_DATA), int'(exp_wdata));
        check({tag, ".frame_cnt"}, int'(FRAME_CNT), exp_cnt);
        check({tag, ".n_wr"}, n_wr, exp_wr);
        check({tag, ".n_rd"}, n_rd, exp_rd);
        check({tag, ".n_err"}, n_err, exp_err);
    endtask

    task automatic sclk_edges(input logic [15:0] w, input int first,
                              input int n);
        for (int i = first; i < first + n; i++) begin
            ADC_SDATA = (i < 16) ? w[15 - i] : 1'($urandom);
            #37 ADC_SCLK = 1'b1;
            #40 ADC_SCLK = 1'b0;
            #3;
        end
    endtask

    task automatic send_frame(input logic [15:0] w, input int n);
        ADC_SLOAD = 1'b0;
        #63;
        sclk_edges(w, 0, n);
        #37 ADC_SLOAD = 1'b1;
        ADC_SDATA = 1'b0;
        #80;
        model_frame(w, n);
    endtask

    logic [15:0] w;
    int          n;
    string       tag;

    initial begin
        model_reset();
        repeat (4) @(negedge CLK);
        RESET_N = 1'b1;
        check_outputs("reset");

        // SLOAD low on reset release must not open a frame.
        sclk_edges(16'hFFFF, 0, 4);
        ADC_SLOAD = 1'b1;
        #80;
        check_outputs("sload_low_at_reset");

        send_frame(16'h0050, 16);
        check_outputs("write_cfg");
        send_frame(16'h2025, 16);
        send_frame(16'h51FF, 16);
        check_outputs("back_to_back");
        check("gain_val", int'(GAIN), 'h25);
        check("offset_val", int'(OFFSET), 'h1FF);
        send_frame(16'hA123, 12);
        send_frame(16'h3155, 18);
        check_outputs("short_long");
        send_frame(16'hD000, 16);
        check_outputs("read");
        send_frame(16'h0000, 0);
        check_outputs("zero_edges");

        // Reset in the middle of a frame.
        ADC_SLOAD = 1'b0;
        #63;
        sclk_edges(16'h4ABC, 0, 8);
        @(negedge CLK) RESET_N = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        model_reset();
        check_outputs("mid_reset");
        sclk_edges(16'h4ABC, 8, 8);
        #37 ADC_SLOAD = 1'b1;
        #80;
        check_outputs("mid_reset_tail");
        send_frame(16'h5077, 16);
        check_outputs("after_reset");

        for (int k = 0; k < 30; k++) begin
            w = 16'($urandom);
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : 16;
            send_frame(w, n);
            tag = $sformatf("rand%0d", k);
            check_outputs(tag);
        end

        // Count wrap: keep sending valid frames until the model wraps.
        for (int k = 0; k < 256; k++) begin
            w = 16'($urandom);
            send_frame(w, 16);
            if (exp_cnt == 0) check_outputs("wrap");
        end
        check_outputs("final");
        check("one_hot_pulses", n_ovl, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
